// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (centre-sampled, 2-FF synchronised input) feeding a show-ahead byte FIFO.
// Head byte is visible with no read latency; a push is dropped and flagged when the FIFO is full.
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          rx_pop,
  output logic [7:0]                    r_data,
  output logic                          receiver_valid,
  output logic                          ferr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

  localparam int P  = 2 * CLK_PER_HALF_BIT;
  localparam int CW = $clog2(P);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(P - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            push_q;
  logic            ferr_q;
  logic            rx_meta_q;
  logic            rx_s_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic            overrun_q;
  logic            do_push;
  logic            do_pop;
  logic            full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A start bit that is high again at its centre was only a glitch.
            state_q   <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BRK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BRK: begin
          // Hold off until the line returns high so a break is not read as 0x00.
          cnt_q <= '0;
          if (rx_s_q) state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign full    = (count_q == DEPTH);
  assign do_pop  = rx_pop && (count_q != '0);
  assign do_push = push_q && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push_q && !do_push) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign receiver_valid = (count_q != '0);
  assign r_data         = receiver_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign ferr           = ferr_q;
  assign overrun        = overrun_q;
  assign rx_count       = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are bit-banged on uart_rx, expected bytes queued and
// compared as they are popped from the FIFO.
module tb_uart_rx_fifo;

  localparam int H = 4;
  localparam int D = 4;
  localparam int P = 2 * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_pop;
  logic [7:0] r_data;
  logic       receiver_valid;
  logic       ferr;
  logic       overrun;
  logic [2:0] rx_count;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int f0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_pop(rx_pop),
    .r_data(r_data), .receiver_valid(receiver_valid), .ferr(ferr),
    .overrun(overrun), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ferr === 1'b1) ferr_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      uart_rx = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_pop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      uart_rx = ~uart_rx;
    end
    rst = 1'b0;
    uart_rx = 1'b1;
  endtask

  // Bit-bang one frame; optionally pop the head during the FIFO push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic keep,
                            input logic pop_at_push);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (stop && keep) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < P; j++) begin
        @(negedge clk);
        uart_rx = bits[i];
        if (pop_at_push && i == 9 && j == P - 1) begin
          chk("head_at_push", r_data, exp_q[0]);
          void'(exp_q.pop_front());
          rx_pop = 1'b1;
        end
      end
    end
    if (pop_at_push) begin
      @(negedge clk);
      rx_pop = 1'b0;
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 200 && receiver_valid !== 1'b1; n++) @(negedge clk);
    chk(tag, receiver_valid, 1);
  endtask

  task automatic pop_check(input string tag);
    wait_valid({tag, "_valid"});
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<nothing queued>", tag, r_data);
    end else begin
      chk(tag, r_data, exp_q.pop_front());
    end
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    rx_pop = 1'b0;

    // Reset with the line toggling
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      uart_rx = ~uart_rx;
    end
    chk("rst_valid", receiver_valid, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    uart_rx = 1'b1;
    idle(5);

    // Pop on empty FIFO has no effect
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    @(negedge clk);
    chk("empty_pop_count", rx_count, 0);
    chk("empty_pop_valid", receiver_valid, 0);

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_valid("a5_valid");
    chk("a5_count", rx_count, 1);
    pop_check("a5_data");
    chk("a5_valid_after_pop", receiver_valid, 0);
    chk("a5_count_after_pop", rx_count, 0);
    idle(4);

    // Glitch on the start bit
    f0 = ferr_seen;
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b0;
    idle(30);
    chk("glitch_ferr", ferr_seen - f0, 0);
    chk("glitch_count", rx_count, 0);
    chk("glitch_valid", receiver_valid, 0);

    // Framing error followed by a break, then a good frame
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20) begin
      @(negedge clk);
      uart_rx = 1'b0;
    end
    idle(10);
    chk("ferr_pulses", ferr_seen - f0, 1);
    chk("ferr_count", rx_count, 0);
    chk("ferr_valid", receiver_valid, 0);
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    pop_check("after_ferr_data");
    idle(4);

    // Overrun: five bytes into a four-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, (k <= 4) ? 1'b1 : 1'b0, 1'b0);
      idle(2);
    end
    idle(4);
    chk("ovr_count", rx_count, 4);
    chk("ovr_flag", overrun, 1);
    for (int k = 0; k < 4; k++) pop_check("ovr_data");
    idle(2);
    chk("ovr_drained_valid", receiver_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Reset mid-frame: partial byte must never appear
    do_reset();
    chk("rst2_overrun", overrun, 0);
    @(negedge clk); uart_rx = 1'b0;
    repeat (30) @(negedge clk);
    do_reset();
    idle(100);
    chk("midframe_count", rx_count, 0);
    chk("midframe_valid", receiver_valid, 0);

    // Full FIFO with a pop in the push cycle of a fifth byte
    for (int k = 0; k < 4; k++) begin
      send_frame(8'hA1 + 8'(k), 1'b1, 1'b1, 1'b0);
      idle(2);
    end
    idle(4);
    chk("full_count", rx_count, 4);
    send_frame(8'h77, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("full_pop_overrun", overrun, 0);
    chk("full_pop_count", rx_count, 4);
    for (int k = 0; k < 4; k++) pop_check("full_pop_data");
    idle(2);
    chk("final_valid", receiver_valid, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
